// File: rtl/crc_sig_harness.sv
// LFSR stimulus and result-signature stage that wraps a type-parameterised DUT.
// Optional X/Z detection on the result input is enabled by defining CRC_SIG_XCHECK_EN.
`timescale 1ns/1ps
module crc_sig_harness #(
  parameter type         result_t  = logic [63:0],
  parameter logic [63:0] SEED      = 64'h5aef0c8d_d70a4497,
  parameter int unsigned WARMUP    = 10,
  parameter int unsigned CHECK_CYC = 99
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        in_valid,
  input  result_t     result,
  input  logic [63:0] expected_crc,
  input  logic [63:0] expected_sum,
  output logic [63:0] crc,
  output logic [63:0] sum,
  output logic [31:0] cyc,
  output logic        running,
  output logic        done,
  output logic        pass,
  output logic        fail
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int          RW        = $bits(result_t);
  localparam logic [31:0] WARMUP_C  = 32'(WARMUP);
  localparam logic [31:0] CHECK_C   = 32'(CHECK_CYC);

  if ((WARMUP < 1) || (WARMUP >= CHECK_CYC)) begin : g_bad_warmup
    $error("crc_sig_harness: WARMUP must lie in 1..CHECK_CYC-1");
  end
  if (CHECK_CYC >= 32'hffff_ffff) begin : g_bad_check
    $error("crc_sig_harness: CHECK_CYC must be below 2^32-1");
  end

  function automatic logic [63:0] lfsr_step(input logic [63:0] v);
    return {v[62:0], v[63] ^ v[2] ^ v[0]};
  endfunction

  logic [RW-1:0] result_bits;
  logic [63:0]   r64;

  assign result_bits = result;

  if (RW >= 64) begin : g_trunc
    assign r64 = result_bits[63:0];
  end else begin : g_ext
    assign r64 = {{(64-RW){1'b0}}, result_bits};
  end

  state_t      state_q, state_d;
  logic [63:0] crc_q, crc_d;
  logic [63:0] sum_q, sum_d;
  logic [31:0] cyc_q, cyc_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic        fail_q, fail_d;
  logic        match;

  assign match = (crc_q == expected_crc) && (sum_q == expected_sum);

  // Reseed is shared by IDLE and DONE; in RUN start is deliberately ignored.
  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    sum_d   = sum_q;
    cyc_d   = cyc_q;
    done_d  = done_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          cyc_d   = 32'd1;
          crc_d   = SEED;
          sum_d   = 64'd0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          fail_d  = 1'b0;
        end
      end
      RUN: begin
`ifdef CRC_SIG_XCHECK_EN
        if ((cyc_q >= WARMUP_C) && in_valid && $isunknown(result)) begin
          state_d = DONE;
          done_d  = 1'b1;
          pass_d  = 1'b0;
          fail_d  = 1'b1;
        end else
`endif
        if (cyc_q == CHECK_C) begin
          state_d = DONE;
          done_d  = 1'b1;
          pass_d  = match;
          fail_d  = ~match;
        end else begin
          cyc_d = cyc_q + 32'd1;
          crc_d = lfsr_step(crc_q);
          if (cyc_q < WARMUP_C) begin
            sum_d = 64'd0;
          end else if (in_valid) begin
            sum_d = r64 ^ lfsr_step(sum_q);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      crc_q   <= 64'd0;
      sum_q   <= 64'd0;
      cyc_q   <= 32'd0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      sum_q   <= sum_d;
      cyc_q   <= cyc_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
    end
  end

  assign crc     = crc_q;
  assign sum     = sum_q;
  assign cyc     = cyc_q;
  assign running = (state_q == RUN);
  assign done    = done_q;
  assign pass    = pass_q;
  assign fail    = fail_q;

endmodule
